// File: rtl/fu_cdb_tx.sv
// rtl/fu_cdb_tx.sv - per-FU result FIFO that presents its head packet to the CDB arbiter.
// Optional zero-latency bypass when the FIFO is empty: define FU_CDB_BYPASS_EN.
package fu_cdb_tx_pkg;
  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] result;
  } fu_packet_t;
endpackage

module fu_cdb_tx
  import fu_cdb_tx_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  fu_packet_t       in_packet,
  output logic             in_ready,
  input  logic             flush,
  input  logic             stall_sig,
  output logic             fu_done,
  output fu_packet_t       wr_data,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  fu_packet_t       mem_q [DEPTH];
  fu_packet_t       mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             non_empty;
  logic             bypass;
  logic             push;
  logic             pop;

  always_comb begin
    non_empty = (count_q != '0);
    in_ready  = (count_q < CNT_W'(DEPTH));
`ifdef FU_CDB_BYPASS_EN
    bypass    = !non_empty && in_valid && !flush;
`else
    bypass    = 1'b0;
`endif
    fu_done   = (non_empty && !flush) || bypass;
    if (bypass) begin
      wr_data = in_packet;
    end else if (non_empty) begin
      wr_data = mem_q[head_q];
    end else begin
      wr_data = '0;
    end
    // A bypassed packet granted this cycle is consumed and never stored.
    pop   = non_empty && !flush && !stall_sig;
    push  = in_valid && in_ready && !flush && !(bypass && !stall_sig);
    count = count_q;
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = in_packet;
        tail_d        = (tail_q == LAST) ? '0 : tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = (head_q == LAST) ? '0 : head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_fu_cdb_tx.sv
// tb/tb_fu_cdb_tx.sv - fu_cdb_tx at DEPTH=2 and DEPTH=3 against a queue model, directed then random.
module tb_fu_cdb_tx;
  import fu_cdb_tx_pkg::*;

  localparam int N = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid  [N];
  logic       in_ready  [N];
  logic       flush     [N];
  logic       stall_sig [N];
  logic       fu_done   [N];
  fu_packet_t in_packet [N];
  fu_packet_t wr_data   [N];
  logic [1:0] count     [N];

  always #5 clock = ~clock;

  fu_cdb_tx #(.DEPTH(2)) u_d2 (
    .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_packet(in_packet[0]),
    .in_ready(in_ready[0]), .flush(flush[0]), .stall_sig(stall_sig[0]),
    .fu_done(fu_done[0]), .wr_data(wr_data[0]), .count(count[0])
  );

  fu_cdb_tx #(.DEPTH(3)) u_d3 (
    .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_packet(in_packet[1]),
    .in_ready(in_ready[1]), .flush(flush[1]), .stall_sig(stall_sig[1]),
    .fu_done(fu_done[1]), .wr_data(wr_data[1]), .count(count[1])
  );

  int         errors = 0;
  int         checks = 0;
  bit         chk_en = 1'b0;
  bit         acc [N];
  int         delivered [N];
  int         tag_ctr = 0;
  fu_packet_t mq [N][$];

  task automatic check(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  function automatic fu_packet_t mk(input logic [31:0] r);
    fu_packet_t p;
    tag_ctr++;
    p.tag    = 6'(tag_ctr);
    p.result = r;
    return p;
  endfunction

  // Model: the buffer is just an ordered list of accepted, not yet granted packets.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      int         d;
      int         cnt;
      bit         byp;
      bit         edone;
      fu_packet_t edata;
      d   = (i == 0) ? 2 : 3;
      cnt = mq[i].size();
      if (chk_en) begin
        byp = 1'b0;
`ifdef FU_CDB_BYPASS_EN
        byp = (cnt == 0) && in_valid[i] && !flush[i];
`endif
        edone = ((cnt != 0) && !flush[i]) || byp;
        if (byp)           edata = in_packet[i];
        else if (cnt != 0) edata = mq[i][0];
        else               edata = '0;
        check("fu_done", i, 64'(fu_done[i]), 64'(edone));
        check("wr_data", i, 64'(wr_data[i]), 64'(edata));
        check("in_ready", i, 64'(in_ready[i]), 64'(cnt < d));
        check("count", i, 64'(count[i]), 64'(cnt));
        check("count_bound", i, 64'(int'(count[i]) <= d), 64'd1);
        acc[i] = in_valid[i] && (cnt < d) && !flush[i] && !reset;
        if (reset || flush[i]) begin
          mq[i].delete();
        end else begin
          if (edone && !stall_sig[i]) begin
            if (!byp) void'(mq[i].pop_front());
            delivered[i]++;
          end
          if (acc[i] && !(byp && !stall_sig[i])) mq[i].push_back(in_packet[i]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    check(name, 0, act, exp);
  endtask

  fu_packet_t pa, pb, pc;

  initial begin
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      in_packet[i] = '0;
      flush[i]     = 1'b0;
      stall_sig[i] = 1'b0;
      acc[i]       = 1'b0;
      delivered[i] = 0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    repeat (5) begin
      @(negedge clock);
      lit("idle_done", 64'(fu_done[0]), 64'd0);
      lit("idle_data", 64'(wr_data[0]), 64'd0);
      lit("idle_ready", 64'(in_ready[0]), 64'd1);
      lit("idle_count", 64'(count[0]), 64'd0);
      cyc();
    end

    in_valid[0]  = 1'b1;
    in_packet[0] = mk(32'h1234);
    @(negedge clock);
`ifdef FU_CDB_BYPASS_EN
    lit("single_done0", 64'(fu_done[0]), 64'd1);
    lit("single_result0", 64'(wr_data[0].result), 64'h1234);
    cyc();
    in_valid[0] = 1'b0;
`else
    lit("single_done0", 64'(fu_done[0]), 64'd0);
    cyc();
    in_valid[0] = 1'b0;
    @(negedge clock);
    lit("single_done1", 64'(fu_done[0]), 64'd1);
    lit("single_result1", 64'(wr_data[0].result), 64'h1234);
    cyc();
`endif
    @(negedge clock);
    lit("single_count_after", 64'(count[0]), 64'd0);
    cyc();

    pa = mk(32'hA);
    pb = mk(32'hB);
    pc = mk(32'hC);
    stall_sig[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_packet[0] = pa;
    cyc();
    in_packet[0] = pb;
    @(negedge clock);
    lit("stall_hold_a1", 64'(wr_data[0]), 64'(pa));
    cyc();
    in_packet[0] = pc;
    repeat (2) begin
      @(negedge clock);
      lit("full_count", 64'(count[0]), 64'd2);
      lit("full_ready", 64'(in_ready[0]), 64'd0);
      lit("full_done", 64'(fu_done[0]), 64'd1);
      lit("stall_hold_a", 64'(wr_data[0]), 64'(pa));
      cyc();
    end
    stall_sig[0] = 1'b0;
    @(negedge clock);
    lit("order_a", 64'(wr_data[0]), 64'(pa));
    cyc();
    @(negedge clock);
    lit("order_b", 64'(wr_data[0]), 64'(pb));
    cyc();
    in_valid[0] = 1'b0;
    @(negedge clock);
    lit("order_c", 64'(wr_data[0]), 64'(pc));
    cyc();
    @(negedge clock);
    lit("order_empty", 64'(count[0]), 64'd0);
    cyc();

    stall_sig[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_packet[0] = mk(32'd100);
    cyc();
    stall_sig[0] = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      in_packet[0] = mk(32'd100 + 32'(j));
      @(negedge clock);
      lit("steady_count", 64'(count[0]), 64'd1);
      lit("steady_ready", 64'(in_ready[0]), 64'd1);
      lit("steady_done", 64'(fu_done[0]), 64'd1);
      lit("steady_result", 64'(wr_data[0].result), 64'(100 + j - 1));
      cyc();
    end
    in_valid[0] = 1'b0;
    @(negedge clock);
    lit("steady_last", 64'(wr_data[0].result), 64'd110);
    cyc();

    stall_sig[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_packet[0] = mk(32'd200);
    cyc();
    in_packet[0] = mk(32'd201);
    cyc();
    flush[0]     = 1'b1;
    in_packet[0] = mk(32'd202);
    @(negedge clock);
    lit("flush_done", 64'(fu_done[0]), 64'd0);
    lit("flush_count_before", 64'(count[0]), 64'd2);
    cyc();
    flush[0]     = 1'b0;
    in_valid[0]  = 1'b0;
    stall_sig[0] = 1'b0;
    @(negedge clock);
    lit("flush_count_after", 64'(count[0]), 64'd0);
    lit("flush_done_after", 64'(fu_done[0]), 64'd0);
    lit("flush_data_after", 64'(wr_data[0]), 64'd0);
    cyc();

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] || acc[i] || flush[i] || reset) begin
          in_valid[i] = ($urandom_range(0, 9) < 7);
          if (in_valid[i]) in_packet[i] = mk($urandom);
        end
        stall_sig[i] = 1'($urandom_range(0, 1));
        flush[i]     = ($urandom_range(0, 39) == 0);
      end
      reset = (c == 300);
      cyc();
      if (c == 300) begin
        check("reset_mid_count", 0, 64'(count[0]), 64'd0);
        check("reset_mid_count", 1, 64'(count[1]), 64'd0);
      end
    end
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      flush[i]    = 1'b0;
    end
    reset = 1'b0;
    cyc();
    check("delivered_some", 1, 64'(delivered[1] > 50), 64'd1);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
